sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
- Command/data sequencer that drives the word-level SPI engine (`datain`/`en`/`dataout`/`done`) to run one complete SD-card SPI-mode transaction per request.
- Each transaction: 6-byte command frame, R1 poll, optional single-block read with start-token search, trailing clock byte.
- Sits between the J1 I/O register file and the SPI engine, so firmware issues whole commands instead of individual bytes.
- Received block bytes stream out on a valid strobe.

Parameters:
- NCR_MAX, 8: maximum number of 0xFF poll bytes while waiting for R1 before timeout.
- TOKEN_MAX, 1024: maximum poll bytes while waiting for the 0xFE data token.
- BLOCK_LEN, 512: data bytes per block read.
- CNT_W, 11: width of the shared poll/data counter; must hold max(TOKEN_MAX, BLOCK_LEN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle request pulse; sampled only in IDLE.
- cmd_index  in  6  SD command number.
- cmd_arg  in  32  command argument, sent MSB first.
- cmd_crc  in  7  CRC7 of the command frame.
- cmd_rd_block  in  1  1 = command is followed by a data block read.
- busy  out  1  high from the cycle after an accepted cmd_start until cmd_done.
- cmd_done  out  1  one-cycle completion pulse.
- r1  out  8  last R1 byte received; 0xFF on R1 timeout.
- err  out  2  0 = ok, 1 = R1 timeout, 2 = token timeout, 3 = R1 error bits set.
- rd_data  out  8  block data byte.
- rd_valid  out  1  one-cycle strobe per block byte.
- spi_datain  out  16  word to SPI engine; byte in [7:0], [15:8] = 0.
- spi_en  out  1  one-cycle start pulse to SPI engine.
- spi_dataout  in  16  SPI engine receive word; [7:0] used.
- spi_done  in  1  one-cycle pulse when the SPI transfer completes.

Behaviour:
- Reset: all outputs 0 except r1 = 0xFF; state = IDLE; counters cleared. Reset mid-transfer abandons the transaction and emits no cmd_done. Any later spi_done that arrives in IDLE is ignored.
- Byte transfer primitive (XFER):
  - Cycle 0: spi_datain = {8'h00, tx}, spi_en = 1 for exactly one cycle.
  - Then wait for spi_done; capture spi_dataout[7:0] in that cycle.
  - The next XFER may issue the cycle after capture. spi_en is never reasserted before spi_done.
- States: IDLE, SEND, WAIT_R1, WAIT_TOKEN, READ_DATA, READ_CRC, TRAIL, DONE.
- IDLE:
  - On cmd_start, latch index/arg/crc/rd_block, clear err, go to SEND.
  - busy = 1 from the next cycle.
  - cmd_start while busy is ignored.
- SEND: 6 XFERs with tx = {2'b01, index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc, 1'b1}. Received bytes are discarded. Then go to WAIT_R1 with count = 0.
- WAIT_R1:
  - XFER tx = 0xFF repeatedly.
  - Received byte with bit7 = 0: r1 = byte.
    - If (byte & 0xFE) != 0 → err = 3, go to TRAIL.
    - Else if rd_block → go to WAIT_TOKEN, count = 0.
    - Else → go to TRAIL.
  - Bit7 = 1: count++. When count reaches NCR_MAX, r1 = 0xFF, err = 1, go to TRAIL.
- WAIT_TOKEN:
  - XFER 0xFF repeatedly.
  - Byte 0xFE → READ_DATA, count = 0.
  - Any other byte: count++. At TOKEN_MAX, err = 2, go to TRAIL.
- READ_DATA:
  - XFER 0xFF; on each capture, rd_data = byte and rd_valid = 1 for one cycle.
  - After BLOCK_LEN bytes (count BLOCK_LEN-1 → wrap) go to READ_CRC.
- READ_CRC: 2 XFERs of 0xFF; bytes discarded, not checked, no rd_valid.
- TRAIL: 1 XFER of 0xFF (8 extra clocks required by the card), then DONE.
- DONE: cmd_done = 1 and busy = 0 in the same cycle; r1/err are stable from this cycle until the next accepted cmd_start. Next state IDLE.
- A new cmd_start arriving in the DONE cycle is ignored; it is accepted from IDLE only.
- Counters saturate logically at their limit compares and never wrap silently.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding;
  - err codes: ERR_OK, ERR_R1_TO, ERR_TOK_TO, ERR_R1;
  - constants TOKEN_START = 8'hFE, FILL = 8'hFF, CMD_PREFIX = 2'b01.
- One natural sub-module, sd_xfer_byte: the XFER primitive.
  - Inputs: go, tx[7:0], spi_done, spi_dataout.
  - Outputs: spi_en, spi_datain, rx[7:0], rx_valid.
  - The top-level FSM only issues go and consumes rx_valid.

Test Plan:
- CMD0 (index 0, arg 0, crc 0x4A, rd_block 0); SPI model returns FF, FF, 01 during poll → MOSI bytes 40 00 00 00 00 95, then FF×3, then trailing FF; r1 = 0x01, err = 0, one cmd_done pulse, busy high throughout.
- CMD8 with the model returning only 0xFF, NCR_MAX = 8 → exactly 8 poll XFERs, then trailing FF; r1 = 0xFF, err = 1.
- CMD17 (index 17, arg 0x00000200, rd_block 1); model returns R1 0x00, FF×3, FE, bytes i[7:0] for i = 0..511, CRC 0xAB 0xCD → 512 rd_valid pulses with rd_data = 0..255, 0..255 in order; no strobe on the CRC bytes; err = 0.
- CMD17 with R1 = 0x04 → no token search and no rd_valid; err = 3, r1 = 0x04. Separately, token never sent with TOKEN_MAX = 16 → err = 2 after 16 polls.
- Reset asserted for one cycle during READ_DATA byte 100 → next cycle all outputs at reset values, no cmd_done. A subsequent CMD0 completes normally.
- cmd_start pulsed mid-transaction → ignored: latched arg unchanged, exactly one cmd_done; spi_en never asserted while a transfer is outstanding.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared state encoding, error codes and byte constants for the SD command sequencer
package sd_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_R1, S_WAIT_TOKEN, S_READ_DATA, S_READ_CRC, S_TRAIL, S_DONE
  } state_t;
  localparam logic [1:0] ERR_OK = 2'd0;
  localparam logic [1:0] ERR_R1_TO = 2'd1;
  localparam logic [1:0] ERR_TOK_TO = 2'd2;
  localparam logic [1:0] ERR_R1 = 2'd3;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] FILL = 8'hFF;
  localparam logic [1:0] CMD_PREFIX = 2'b01;
endpackage

// File: rtl/sd_xfer_byte.sv
// sd_xfer_byte: one SPI byte exchange per go (spi_en/spi_datain out, rx/rx_valid back on spi_done); go and spi_done are ignored while a transfer is outstanding or idle respectively
module sd_xfer_byte (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [7:0]  tx,
  input  logic        spi_done,
  input  logic [15:0] spi_dataout,
  output logic        spi_en,
  output logic [15:0] spi_datain,
  output logic [7:0]  rx,
  output logic        rx_valid
);
  logic pend_q, spi_en_q, rx_valid_q;
  logic [15:0] spi_datain_q;
  logic [7:0] rx_q;
  logic unused_hi;
  assign unused_hi = ^spi_dataout[15:8];
  assign spi_en = spi_en_q;
  assign spi_datain = spi_datain_q;
  assign rx = rx_q;
  assign rx_valid = rx_valid_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      spi_en_q <= 1'b0;
      spi_datain_q <= '0;
      rx_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      spi_en_q <= go && !pend_q;
      rx_valid_q <= spi_done && pend_q;
      if (go && !pend_q) begin
        spi_datain_q <= {8'h00, tx};
        pend_q <= 1'b1;
      end else if (spi_done && pend_q) begin
        rx_q <= spi_dataout[7:0];
        pend_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: runs one SD SPI-mode transaction per cmd_start (frame, R1 poll, optional block read, trail byte); ports: cmd_* request, busy/cmd_done/r1/err status, rd_data/rd_valid block stream, spi_* byte engine handshake
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 8,
  parameter int TOKEN_MAX = 1024,
  parameter int BLOCK_LEN = 512,
  parameter int CNT_W = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_rd_block,
  output logic        busy,
  output logic        cmd_done,
  output logic [7:0]  r1,
  output logic [1:0]  err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [15:0] spi_datain,
  output logic        spi_en,
  input  logic [15:0] spi_dataout,
  input  logic        spi_done
);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] NCR_LAST = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] TOK_LAST = CNT_W'(TOKEN_MAX - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_LEN - 1);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic wait_q, busy_q, done_q, rd_valid_q, rdb_q;
  logic [7:0] r1_q, rd_data_q, tx, rx;
  logic [1:0] err_q;
  logic [5:0] idx_q;
  logic [31:0] arg_q;
  logic [6:0] crc_q;
  logic go, rx_valid;
  assign busy = busy_q;
  assign cmd_done = done_q;
  assign r1 = r1_q;
  assign err = err_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  // wait_q covers the whole outstanding exchange, so a new byte is only requested after the previous one is consumed
  assign go = !wait_q && state_q != S_IDLE && state_q != S_DONE;
  always_comb begin
    tx = state_q != S_SEND ? FILL :
         cnt_q[2:0] == 3'd0 ? {CMD_PREFIX, idx_q} :
         cnt_q[2:0] == 3'd1 ? arg_q[31:24] :
         cnt_q[2:0] == 3'd2 ? arg_q[23:16] :
         cnt_q[2:0] == 3'd3 ? arg_q[15:8] :
         cnt_q[2:0] == 3'd4 ? arg_q[7:0] : {crc_q, 1'b1};
  end
  sd_xfer_byte u_xfer (
    .clk(clk),
    .reset(reset),
    .go(go),
    .tx(tx),
    .spi_done(spi_done),
    .spi_dataout(spi_dataout),
    .spi_en(spi_en),
    .spi_datain(spi_datain),
    .rx(rx),
    .rx_valid(rx_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      wait_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      r1_q <= FILL;
      err_q <= ERR_OK;
      idx_q <= '0;
      arg_q <= '0;
      crc_q <= '0;
      rdb_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      if (go) wait_q <= 1'b1;
      if (rx_valid) wait_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_start) begin
          idx_q <= cmd_index;
          arg_q <= cmd_arg;
          crc_q <= cmd_crc;
          rdb_q <= cmd_rd_block;
          err_q <= ERR_OK;
          busy_q <= 1'b1;
          cnt_q <= '0;
          state_q <= S_SEND;
        end
        S_SEND: if (rx_valid) begin
          cnt_q <= cnt_q == SEND_LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == SEND_LAST) state_q <= S_WAIT_R1;
        end
        S_WAIT_R1: if (rx_valid) begin
          if (!rx[7]) begin
            r1_q <= rx;
            cnt_q <= '0;
            if (|rx[7:1]) err_q <= ERR_R1;
            state_q <= (|rx[7:1]) ? S_TRAIL : rdb_q ? S_WAIT_TOKEN : S_TRAIL;
          end else if (cnt_q == NCR_LAST) begin
            r1_q <= FILL;
            err_q <= ERR_R1_TO;
            cnt_q <= '0;
            state_q <= S_TRAIL;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_WAIT_TOKEN: if (rx_valid) begin
          if (rx == TOKEN_START) begin
            cnt_q <= '0;
            state_q <= S_READ_DATA;
          end else if (cnt_q == TOK_LAST) begin
            err_q <= ERR_TOK_TO;
            cnt_q <= '0;
            state_q <= S_TRAIL;
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_READ_DATA: if (rx_valid) begin
          rd_data_q <= rx;
          rd_valid_q <= 1'b1;
          cnt_q <= cnt_q == BLK_LAST ? '0 : cnt_q + 1'b1;
          if (cnt_q == BLK_LAST) state_q <= S_READ_CRC;
        end
        S_READ_CRC: if (rx_valid) begin
          cnt_q <= cnt_q[0] ? '0 : cnt_q + 1'b1;
          if (cnt_q[0]) state_q <= S_TRAIL;
        end
        S_TRAIL: if (rx_valid) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: scoreboard bench driving directed SD commands through a byte-level SPI engine model
module tb_sd_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_start = 1'b0;
  logic [5:0] cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0] cmd_crc = '0;
  logic cmd_rd_block = 1'b0;
  logic busy, cmd_done, rd_valid, spi_en;
  logic [7:0] r1, rd_data;
  logic [1:0] err;
  logic [15:0] spi_datain;
  logic [15:0] spi_dataout = '0;
  logic spi_done = 1'b0;
  int total = 0;
  int bad = 0;
  int rd_seen = 0;
  int done_seen = 0;
  logic [7:0] exp_mosi[$];
  logic [7:0] miso_q[$];
  logic [7:0] exp_rd[$];
  logic [9:0] exp_done[$];
  always #5 clk = ~clk;
  sd_cmd_sequencer #(.NCR_MAX(8), .TOKEN_MAX(16), .BLOCK_LEN(512), .CNT_W(11)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_start(cmd_start),
    .cmd_index(cmd_index),
    .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc),
    .cmd_rd_block(cmd_rd_block),
    .busy(busy),
    .cmd_done(cmd_done),
    .r1(r1),
    .err(err),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .spi_datain(spi_datain),
    .spi_en(spi_en),
    .spi_dataout(spi_dataout),
    .spi_done(spi_done)
  );
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic push_ff(input int n);
    for (int k = 0; k < n; k++) exp_mosi.push_back(8'hFF);
  endtask
  task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    exp_mosi.push_back({2'b01, idx});
    exp_mosi.push_back(arg[31:24]);
    exp_mosi.push_back(arg[23:16]);
    exp_mosi.push_back(arg[15:8]);
    exp_mosi.push_back(arg[7:0]);
    exp_mosi.push_back({crc, 1'b1});
    for (int k = 0; k < 6; k++) miso_q.push_back(8'h00);
  endtask
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc, input logic rd);
    @(posedge clk);
    #2;
    cmd_index = idx;
    cmd_arg = arg;
    cmd_crc = crc;
    cmd_rd_block = rd;
    cmd_start = 1'b1;
    @(posedge clk);
    #2;
    cmd_start = 1'b0;
  endtask
  task automatic wait_done(input int budget, input string nm);
    int busy_bad = 0;
    for (int i = 0; i < budget && cmd_done !== 1'b1; i++) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #2;
    end
    chk({nm, "_done"}, cmd_done, 1);
    chk({nm, "_busy_during"}, busy_bad, 0);
    chk({nm, "_busy_at_done"}, busy, 0);
  endtask
  task automatic drain(input string nm);
    repeat (6) @(posedge clk);
    #2;
    chk({nm, "_mosi_left"}, exp_mosi.size(), 0);
    chk({nm, "_rd_left"}, exp_rd.size(), 0);
    chk({nm, "_done_left"}, exp_done.size(), 0);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_cmd_done"}, cmd_done, 0);
    chk({nm, "_r1"}, r1, 8'hFF);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_rd_valid"}, rd_valid, 0);
    chk({nm, "_rd_data"}, rd_data, 0);
    chk({nm, "_spi_en"}, spi_en, 0);
    chk({nm, "_spi_datain"}, spi_datain, 0);
  endtask
  task automatic cmd0_expect();
    push_frame(6'd0, 32'h0, 7'h4A);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'hFF);
    miso_q.push_back(8'h01);
    push_ff(3);
    miso_q.push_back(8'hFF);
    push_ff(1);
    exp_done.push_back({8'h01, 2'd0});
  endtask
  task automatic cmd17_expect();
    push_frame(6'd17, 32'h0000_0200, 7'h2A);
    miso_q.push_back(8'h00);
    push_ff(1);
    repeat (3) miso_q.push_back(8'hFF);
    miso_q.push_back(8'hFE);
    push_ff(4);
    for (int i = 0; i < 512; i++) begin
      miso_q.push_back(i[7:0]);
      exp_rd.push_back(i[7:0]);
    end
    push_ff(512);
    miso_q.push_back(8'hAB);
    miso_q.push_back(8'hCD);
    push_ff(2);
    miso_q.push_back(8'hFF);
    push_ff(1);
    exp_done.push_back({8'h00, 2'd0});
  endtask
  // SPI engine model: checks each MOSI byte, answers after a few cycles, and checks spi_en stays low meanwhile
  initial begin
    logic [7:0] resp;
    forever begin
      @(posedge clk);
      #1;
      if (spi_en) begin
        if (exp_mosi.size() == 0) chk("mosi_extra", exp_mosi.size(), 1);
        else chk("mosi", spi_datain, {8'h00, exp_mosi.pop_front()});
        resp = miso_q.size() != 0 ? miso_q.pop_front() : 8'hFF;
        repeat (2) begin
          @(posedge clk);
          #1;
          chk("spi_en_outstanding", spi_en, 0);
        end
        spi_dataout = {8'h00, resp};
        spi_done = 1'b1;
        @(posedge clk);
        #1;
        spi_done = 1'b0;
        spi_dataout = 16'h5A5A;
      end
    end
  end
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        rd_seen++;
        if (exp_rd.size() == 0) chk("rd_extra", exp_rd.size(), 1);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (cmd_done) begin
        done_seen++;
        if (exp_done.size() == 0) chk("done_extra", exp_done.size(), 1);
        else begin
          e = exp_done.pop_front();
          chk("r1", r1, e[9:2]);
          chk("err", err, e[1:0]);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
  initial begin
    int base;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    chk_reset("por");
    cmd0_expect();
    start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    wait_done(400, "cmd0");
    drain("cmd0");
    push_frame(6'd8, 32'h0000_01AA, 7'h43);
    push_ff(8);
    push_ff(1);
    exp_done.push_back({8'hFF, 2'd1});
    start_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
    wait_done(400, "cmd8_r1to");
    drain("cmd8_r1to");
    cmd17_expect();
    start_cmd(6'd17, 32'h0000_0200, 7'h2A, 1'b1);
    wait_done(6000, "cmd17");
    drain("cmd17");
    push_frame(6'd17, 32'h0000_0200, 7'h2A);
    miso_q.push_back(8'h04);
    push_ff(1);
    miso_q.push_back(8'hFF);
    push_ff(1);
    exp_done.push_back({8'h04, 2'd3});
    start_cmd(6'd17, 32'h0000_0200, 7'h2A, 1'b1);
    wait_done(400, "cmd17_r1err");
    drain("cmd17_r1err");
    push_frame(6'd17, 32'h0000_0400, 7'h11);
    miso_q.push_back(8'h00);
    push_ff(1);
    push_ff(16);
    push_ff(1);
    exp_done.push_back({8'h00, 2'd2});
    start_cmd(6'd17, 32'h0000_0400, 7'h11, 1'b1);
    wait_done(600, "cmd17_tokto");
    drain("cmd17_tokto");
    base = rd_seen;
    cmd17_expect();
    start_cmd(6'd17, 32'h0000_0200, 7'h2A, 1'b1);
    for (int i = 0; i < 3000 && rd_seen - base < 100; i++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_at_byte", rd_seen - base, 100);
    base = done_seen;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_reset("midrst");
    exp_mosi.delete();
    miso_q.delete();
    exp_rd.delete();
    exp_done.delete();
    repeat (20) @(posedge clk);
    #2;
    chk("midrst_no_done", done_seen - base, 0);
    chk("midrst_idle_busy", busy, 0);
    cmd0_expect();
    start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    wait_done(400, "cmd0_after_rst");
    drain("cmd0_after_rst");
    base = done_seen;
    cmd0_expect();
    start_cmd(6'd0, 32'h0, 7'h4A, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    cmd_index = 6'd17;
    cmd_arg = 32'hDEAD_BEEF;
    cmd_crc = 7'h7F;
    cmd_start = 1'b1;
    @(posedge clk);
    #2;
    cmd_start = 1'b0;
    wait_done(400, "cmd0_ignore");
    cmd_start = 1'b1;
    @(posedge clk);
    #2;
    cmd_start = 1'b0;
    drain("cmd0_ignore");
    chk("ignore_one_done", done_seen - base, 1);
    chk("ignore_done_cycle_start", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
